rect_sum_responder: RTL and testbench

RECT_SUM_RESPONDER -- requirements
Module: rect_sum_responder

---
 rtl/rect_sum_responder.sv | 210 +++++++++++++++++++++
 tb/tb_rect_sum_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rect_sum_responder.sv
// Rectangle-sum responder: answers one rectangle query at a time from an
// integral-image memory by combining corner words as D - B - C + A.
module rect_sum_responder #(
  parameter int SUM_WIDTH  = 24,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           query_x1,
  input  logic [15:0]           query_y1,
  input  logic [15:0]           query_x2,
  input  logic [15:0]           query_y2,
  input  logic                  query_valid,
  output logic [SUM_WIDTH-1:0]  rect_sum,
  output logic                  rect_sum_valid,
  output logic                  rect_err,
  output logic                  busy,
  output logic                  ii_rd_en,
  output logic [ADDR_WIDTH-1:0] ii_addr,
  input  logic [SUM_WIDTH-1:0]  ii_data
);

  // state   | meaning
  // IDLE    | waiting for query_valid; coordinates latched on acceptance
  // FETCH   | one corner read per cycle (D, B, C, A; absent corners skipped)
  // DRAIN   | last read's data arrives and is folded into the accumulator
  // RESP    | result registered onto the outputs together with the strobe
  // RELEASE | result held until the initiator drops query_valid
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, RESP, RELEASE} state_e;
  typedef enum logic [1:0] {TERM_D, TERM_B, TERM_C, TERM_A} term_e;

  localparam logic [16:0] IMG_W17 = 17'(IMG_WIDTH);
  localparam logic [16:0] IMG_H17 = 17'(IMG_HEIGHT);

  state_e                state_q, state_d;
  term_e                 step_q, step_d;
  logic [15:0]           x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [SUM_WIDTH-1:0]  acc_q, acc_d;
  logic [SUM_WIDTH-1:0]  rsum_q, rsum_d;
  logic                  rerr_q, rerr_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  hold_q, hold_d;
  logic                  pend_q, pend_d;
  logic                  pend_sub_q, pend_sub_d;

  logic                  q_illegal;
  logic [3:0]            need;
  logic                  nxt_found;
  term_e                 nxt_term;
  logic [15:0]           rd_x, rd_y;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign q_illegal = (query_x1 > query_x2) || (query_y1 > query_y2) ||
                     ({1'b0, query_x2} >= IMG_W17) || ({1'b0, query_y2} >= IMG_H17);

  // Corners on row -1 or column -1 contribute zero and are never read.
  assign need = {(x1_q != 16'd0) && (y1_q != 16'd0), x1_q != 16'd0, y1_q != 16'd0, 1'b1};

  always_comb begin
    nxt_found = 1'b0;
    nxt_term  = step_q;
    for (int k = 3; k >= 1; k--) begin
      if ((k > int'(step_q)) && need[k]) begin
        nxt_found = 1'b1;
        nxt_term  = term_e'(2'(k));
      end
    end
  end

  always_comb begin
    rd_x = x2_q;
    rd_y = y2_q;
    case (step_q)
      TERM_D: begin
        rd_x = x2_q;
        rd_y = y2_q;
      end
      TERM_B: begin
        rd_x = x2_q;
        rd_y = y1_q - 16'd1;
      end
      TERM_C: begin
        rd_x = x1_q - 16'd1;
        rd_y = y2_q;
      end
      default: begin
        rd_x = x1_q - 16'd1;
        rd_y = y1_q - 16'd1;
      end
    endcase
  end

  assign rd_addr = ADDR_WIDTH'(rd_y) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(rd_x);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x2_d       = x2_q;
    y2_d       = y2_q;
    acc_d      = acc_q;
    rsum_d     = rsum_q;
    rerr_d     = rerr_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    hold_d     = hold_q;
    pend_d     = 1'b0;
    pend_sub_d = 1'b0;
    ii_rd_en   = 1'b0;
    ii_addr    = '0;

    if (pend_q) begin
      acc_d = pend_sub_q ? (acc_q - ii_data) : (acc_q + ii_data);
    end

    case (state_q)
      IDLE: begin
        if (query_valid) begin
          x1_d    = query_x1;
          y1_d    = query_y1;
          x2_d    = query_x2;
          y2_d    = query_y2;
          acc_d   = '0;
          step_d  = TERM_D;
          err_d   = q_illegal;
          hold_d  = q_illegal;
          state_d = q_illegal ? RESP : FETCH;
        end
      end
      FETCH: begin
        ii_rd_en   = 1'b1;
        ii_addr    = rd_addr;
        pend_d     = 1'b1;
        pend_sub_d = (step_q == TERM_B) || (step_q == TERM_C);
        if (nxt_found) begin
          step_d = nxt_term;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RESP;
      end
      RESP: begin
        // An illegal query waits one cycle here so its strobe lines up with
        // a zero-read legal query (no read pipeline to drain).
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          rsum_d  = err_q ? '0 : acc_q;
          rerr_d  = err_q;
          valid_d = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!query_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= TERM_D;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      acc_q      <= '0;
      rsum_q     <= '0;
      rerr_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_sub_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      x2_q       <= x2_d;
      y2_q       <= y2_d;
      acc_q      <= acc_d;
      rsum_q     <= rsum_d;
      rerr_q     <= rerr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      pend_sub_q <= pend_sub_d;
    end
  end

  assign rect_sum       = rsum_q;
  assign rect_err       = rerr_q;
  assign rect_sum_valid = valid_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_rect_sum_responder.sv
// Directed bench for rect_sum_responder against an all-ones integral image,
// plus a hand-built memory for the modulo-wrap case.
module tb_rect_sum_responder;

  localparam int SW = 24;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   query_x1 = '0, query_y1 = '0, query_x2 = '0, query_y2 = '0;
  logic          query_valid = 1'b0;
  logic [SW-1:0] rect_sum;
  logic          rect_sum_valid;
  logic          rect_err;
  logic          busy;
  logic          ii_rd_en;
  logic [AW-1:0] ii_addr;
  logic [SW-1:0] ii_data = '0;

  int checks = 0;
  int passes = 0;
  bit wrap_mode = 1'b0;
  logic [AW-1:0] rd_log[$];

  rect_sum_responder #(
    .SUM_WIDTH(SW), .IMG_WIDTH(64), .IMG_HEIGHT(64), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .query_x1(query_x1), .query_y1(query_y1),
    .query_x2(query_x2), .query_y2(query_y2),
    .query_valid(query_valid),
    .rect_sum(rect_sum), .rect_sum_valid(rect_sum_valid), .rect_err(rect_err),
    .busy(busy), .ii_rd_en(ii_rd_en), .ii_addr(ii_addr), .ii_data(ii_data)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] mem_word(input logic [AW-1:0] a);
    int x, y;
    if (wrap_mode) begin
      if (a == 12'd129) return 24'h000005;
      if (a == 12'd1) return 24'hFFFFFE;
      return '0;
    end
    x = int'(a) % 64;
    y = int'(a) / 64;
    return SW'((x + 1) * (y + 1));
  endfunction

  always @(posedge clk) begin
    if (ii_rd_en) begin
      ii_data <= mem_word(ii_addr);
      rd_log.push_back(ii_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rd_at(input int i);
    if (i < rd_log.size()) return 32'(rd_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic start_q(input int x1, input int y1, input int x2, input int y2);
    @(negedge clk);
    query_x1 = 16'(x1);
    query_y1 = 16'(y1);
    query_x2 = 16'(x2);
    query_y2 = 16'(y2);
    query_valid = 1'b1;
    rd_log.delete();
  endtask

  // Next posedge is the capture edge; strobe edge counted from there.
  task automatic finish_q(input string tag, input int exp_sum, input int exp_err,
                          input int exp_edge, input int exp_reads, input int hold,
                          input bit early);
    int n;
    int pulses;
    @(posedge clk);
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    query_x1 = 16'hFFFF;
    query_y1 = 16'h0000;
    query_x2 = 16'h0003;
    query_y2 = 16'h0007;
    if (early) query_valid = 1'b0;
    n = 0;
    while (!rect_sum_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_edge"}, 32'(n), 32'(exp_edge));
    chk({tag, "_sum"}, 32'(rect_sum), 32'(exp_sum));
    chk({tag, "_err"}, 32'(rect_err), 32'(exp_err));
    chk({tag, "_reads"}, 32'(rd_log.size()), 32'(exp_reads));
    pulses = rect_sum_valid ? 1 : 0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (rect_sum_valid) pulses++;
    end
    @(negedge clk);
    query_valid = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (rect_sum_valid) pulses++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_sum_hold"}, 32'(rect_sum), 32'(exp_sum));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", 32'(rect_sum), 32'd0);
    chk("rst_valid", 32'(rect_sum_valid), 32'd0);
    chk("rst_err", 32'(rect_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(ii_rd_en), 32'd0);
    chk("rst_addr", 32'(ii_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_q(2, 3, 5, 6);
    finish_q("full", 16, 0, 6, 4, 0, 1'b0);
    chk("full_addr0", rd_at(0), 32'd389);
    chk("full_addr1", rd_at(1), 32'd133);
    chk("full_addr2", rd_at(2), 32'd385);
    chk("full_addr3", rd_at(3), 32'd129);

    start_q(0, 0, 3, 3);
    finish_q("origin", 16, 0, 3, 1, 0, 1'b0);
    chk("origin_addr0", rd_at(0), 32'd195);

    start_q(0, 4, 7, 4);
    finish_q("row", 8, 0, 4, 2, 0, 1'b0);
    chk("row_addr0", rd_at(0), 32'd263);
    chk("row_addr1", rd_at(1), 32'd199);

    start_q(0, 0, 64, 0);
    finish_q("x2_oob", 0, 1, 2, 0, 0, 1'b0);

    start_q(2, 2, 3, 3);
    finish_q("legal_after_err", 4, 0, 6, 4, 0, 1'b0);

    start_q(5, 0, 4, 0);
    finish_q("x_swap", 0, 1, 2, 0, 0, 1'b0);

    start_q(0, 0, 0, 64);
    finish_q("y2_oob", 0, 1, 2, 0, 0, 1'b0);

    wrap_mode = 1'b1;
    start_q(0, 1, 1, 2);
    finish_q("wrap", 7, 0, 4, 2, 0, 1'b0);
    wrap_mode = 1'b0;

    start_q(1, 1, 2, 2);
    finish_q("early_drop", 4, 0, 6, 4, 0, 1'b1);

    start_q(1, 2, 3, 5);
    finish_q("hold10", 12, 0, 6, 4, 10, 1'b0);

    start_q(2, 3, 5, 6);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_rd_en", 32'(ii_rd_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum", 32'(rect_sum), 32'd0);
    chk("mid_rst_rd_en", 32'(ii_rd_en), 32'd0);
    chk("mid_rst_addr", 32'(ii_addr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_log.delete();
    finish_q("reserve", 16, 0, 6, 4, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
